// File: rtl/se_leak_monitor_pkg.sv
// se_leak_monitor_pkg: shared FSM state type and default sizing for the SE leak monitor
package se_leak_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_RESULT_W = 128;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_TIMEOUT  = 1024;

endpackage

// File: rtl/se_side_capture.sv
// se_side_capture: first-valid latency and result capture for one SE copy
module se_side_capture
    import se_leak_monitor_pkg::*;
#(
    parameter int RESULT_W = DEF_RESULT_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                run,
    input  logic                expire,
    input  logic                valid,
    input  logic [CNT_W-1:0]    cyc,
    input  logic [RESULT_W-1:0] result,
    output logic                captured,
    output logic [CNT_W-1:0]    latency,
    output logic [RESULT_W-1:0] stored
);

    // capture only the first valid of a transaction; a side still silent at expiry reads all-ones
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            captured <= 1'b0;
            latency  <= '0;
            stored   <= '0;
        end else if (clear) begin
            captured <= 1'b0;
            latency  <= '0;
            stored   <= '0;
        end else if (run && valid && !captured) begin
            captured <= 1'b1;
            latency  <= cyc;
            stored   <= result;
        end else if (expire && !captured) begin
            latency  <= '1;
        end
    end

endmodule

// File: rtl/se_leak_monitor.sv
// se_leak_monitor: compares timing and results of two SE copies for one transaction
module se_leak_monitor
    import se_leak_monitor_pkg::*;
#(
    parameter int RESULT_W = DEF_RESULT_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_fire,
    input  logic                validOne,
    input  logic                validTwo,
    input  logic [RESULT_W-1:0] resultOne,
    input  logic [RESULT_W-1:0] resultTwo,
    output logic                out_ready,
    output logic [CNT_W-1:0]    latencyOne,
    output logic [CNT_W-1:0]    latencyTwo,
    output logic [CNT_W-1:0]    skew,
    output logic                timingLeak,
    output logic                timingLeakDone,
    output logic                resultMismatch,
    output logic                timeout,
    output logic                bothValid,
    output logic                busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cyc;
    logic                start, run, done, expire, all_cap, cap_one, cap_two;
    logic [RESULT_W-1:0] res_one, res_two;
    logic [CNT_W-1:0]    skew_live, skew_q;
    logic                mis_live, mis_q, leak_q, tmo_q;

    assign start     = (state == IDLE) && in_fire;
    assign run       = (state == RUN);
    assign done      = (state == DONE);
    assign expire    = run && (cyc == LAST);
    assign all_cap   = (cap_one || validOne) && (cap_two || validTwo);
    assign bothValid = validOne & validTwo;

    se_side_capture #(.RESULT_W(RESULT_W), .CNT_W(CNT_W)) u_one (
        .clock(clock), .reset(reset), .clear(start), .run(run), .expire(expire),
        .valid(validOne), .cyc(cyc), .result(resultOne),
        .captured(cap_one), .latency(latencyOne), .stored(res_one)
    );

    se_side_capture #(.RESULT_W(RESULT_W), .CNT_W(CNT_W)) u_two (
        .clock(clock), .reset(reset), .clear(start), .run(run), .expire(expire),
        .valid(validTwo), .cyc(cyc), .result(resultTwo),
        .captured(cap_two), .latency(latencyTwo), .stored(res_two)
    );

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // next state: RUN ends once both sides report or the cycle budget is spent
    always_comb begin
        state_n = start ? RUN :
                  (run && (all_cap || expire)) ? DONE :
                  done ? IDLE : state;
    end

    // FSM outputs
    always_comb begin
        out_ready      = run;
        busy           = run;
        timingLeakDone = done;
    end

    // transaction cycle counter, saturating
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                  cyc <= '0;
        else if (start)             cyc <= '0;
        else if (run && cyc != '1)  cyc <= cyc + 1'b1;
    end

    // verdict live in DONE from the final captures, held afterwards until the next transaction
    assign skew_live      = (latencyOne >= latencyTwo) ? latencyOne - latencyTwo : latencyTwo - latencyOne;
    assign mis_live       = !tmo_q && (res_one != res_two);
    assign skew           = done ? skew_live : skew_q;
    assign resultMismatch = done ? mis_live : mis_q;
    assign timingLeak     = leak_q;
    assign timeout        = tmo_q;

    // leak and timeout flags accumulate in RUN; DONE snapshots the verdict for holding
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            leak_q <= 1'b0;
            tmo_q  <= 1'b0;
            mis_q  <= 1'b0;
            skew_q <= '0;
        end else if (start) begin
            leak_q <= 1'b0;
            tmo_q  <= 1'b0;
            mis_q  <= 1'b0;
            skew_q <= '0;
        end else if (run) begin
            leak_q <= leak_q || ((validOne != validTwo) && !(cap_one && cap_two)) || (expire && !all_cap);
            tmo_q  <= tmo_q || (expire && !all_cap);
        end else if (done) begin
            mis_q  <= mis_live;
            skew_q <= skew_live;
        end
    end

endmodule

// File: tb/tb_se_leak_monitor.sv
// tb_se_leak_monitor: scoreboard bench for se_leak_monitor with directed transactions
module tb_se_leak_monitor;

    typedef struct {
        logic [15:0] l1;
        logic [15:0] l2;
        logic [15:0] sk;
        logic        lk;
        logic        mi;
        logic        to;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_fire = 1'b0;
    logic         validOne = 1'b0;
    logic         validTwo = 1'b0;
    logic [127:0] resultOne = '0;
    logic [127:0] resultTwo = '0;
    logic         out_ready, timingLeak, timingLeakDone, resultMismatch, timeout, bothValid, busy;
    logic [15:0]  latencyOne, latencyTwo, skew;

    exp_t sb[$];
    exp_t m;
    int   checks = 0;
    int   fails = 0;

    se_leak_monitor #(.RESULT_W(128), .CNT_W(16), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .in_fire(in_fire),
        .validOne(validOne), .validTwo(validTwo),
        .resultOne(resultOne), .resultTwo(resultTwo),
        .out_ready(out_ready), .latencyOne(latencyOne), .latencyTwo(latencyTwo),
        .skew(skew), .timingLeak(timingLeak), .timingLeakDone(timingLeakDone),
        .resultMismatch(resultMismatch), .timeout(timeout),
        .bothValid(bothValid), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one transaction: fire, drive valid pulses at the given RUN cycles, check RUN length
    task automatic txn(input int t1, input int t2, input logic [127:0] r1, input logic [127:0] r2,
                       input int fire_at, input int run_len, input exp_t e);
        int n;
        sb.push_back(e);
        @(posedge clock); #1 in_fire = 1'b1;
        @(posedge clock); #1 in_fire = 1'b0;
        resultOne = r1;
        resultTwo = r2;
        n = 0;
        do begin
            validOne = (n == t1);
            validTwo = (n == t2);
            in_fire  = (n == fire_at);
            @(posedge clock); #1;
            n++;
        end while (busy && n < 40);
        validOne = 1'b0;
        validTwo = 1'b0;
        in_fire  = 1'b0;
        chk("run_len", 128'(n), 128'(run_len));
        @(posedge clock); #1;
        chk("held_leak", 128'(timingLeak), 128'(e.lk));
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (timingLeakDone) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got pulse expected none");
            end else begin
                m = sb.pop_front();
                chk("latencyOne", 128'(latencyOne), 128'(m.l1));
                chk("latencyTwo", 128'(latencyTwo), 128'(m.l2));
                chk("skew", 128'(skew), 128'(m.sk));
                chk("timingLeak", 128'(timingLeak), 128'(m.lk));
                chk("resultMismatch", 128'(resultMismatch), 128'(m.mi));
                chk("timeout", 128'(timeout), 128'(m.to));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_ready", 128'(out_ready), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_latencyOne", 128'(latencyOne), 128'(0));
        chk("rst_skew", 128'(skew), 128'(0));
        chk("rst_leak", 128'(timingLeak), 128'(0));
        reset = 1'b0;
        validOne = 1'b1;
        validTwo = 1'b1;
        #1 chk("bothValid_11", 128'(bothValid), 128'(1));
        validTwo = 1'b0;
        #1 chk("bothValid_10", 128'(bothValid), 128'(0));
        validOne = 1'b0;
        @(posedge clock); #1;
        chk("idle_out_ready", 128'(out_ready), 128'(0));

        txn(5, 5, 128'h1234, 128'h1234, -1, 6,  '{16'd5, 16'd5, 16'd0, 1'b0, 1'b0, 1'b0});
        txn(3, 7, 128'h77, 128'h77, -1, 8,      '{16'd3, 16'd7, 16'd4, 1'b1, 1'b0, 1'b0});
        txn(2, 2, 128'h1, 128'h2, -1, 3,        '{16'd2, 16'd2, 16'd0, 1'b0, 1'b1, 1'b0});
        txn(4, -1, 128'h5, 128'h0, -1, 16,      '{16'd4, 16'hFFFF, 16'hFFFB, 1'b1, 1'b0, 1'b1});
        txn(6, 6, 128'h9, 128'h9, 2, 7,         '{16'd6, 16'd6, 16'd0, 1'b0, 1'b0, 1'b0});

        @(posedge clock); #1 in_fire = 1'b1;
        @(posedge clock); #1 in_fire = 1'b0;
        for (int c = 0; c < 3; c++) begin
            validOne = (c == 1);
            @(posedge clock); #1;
        end
        validOne = 1'b0;
        chk("pre_rst_leak", 128'(timingLeak), 128'(1));
        reset = 1'b1;
        #1;
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_out_ready", 128'(out_ready), 128'(0));
        chk("midrst_latencyOne", 128'(latencyOne), 128'(0));
        chk("midrst_leak", 128'(timingLeak), 128'(0));
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 chk("post_rst_idle", 128'(busy), 128'(0));

        txn(9, 2, 128'hABC, 128'hABC, -1, 10, '{16'd9, 16'd2, 16'd7, 1'b1, 1'b0, 1'b0});
        txn(0, 0, 128'h3, 128'h3, -1, 1,      '{16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0});

        repeat (4) @(posedge clock);
        #1 chk("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/se_leak_monitor.md
SE_LEAK_MONITOR -- requirements
Module: se_leak_monitor

Interface
REQ-001 Parameter RESULT_W, default 128, result width of each SE output.
REQ-002 Parameter CNT_W, default 16, width of cycle and latency counters.
REQ-003 Parameter TIMEOUT, default 1024, cycles in RUN before the transaction is abandoned.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_fire  input  1  one-cycle pulse; a request was accepted by both SE copies (io_in_valid & io_in_ready).
REQ-007 validOne / validTwo  input  1 each  io_out_valid of SE copy one / two.
REQ-008 resultOne / resultTwo  input  RESULT_W each  io_out_result of SE copy one / two.
REQ-009 out_ready  output  1  io_out_ready, driven to both SE copies.
REQ-010 latencyOne / latencyTwo  output  CNT_W each  captured cycles from start to each copy's first valid.
REQ-011 skew  output  CNT_W  |latencyOne - latencyTwo|, valid when done is high.
REQ-012 timingLeak  output  1  sticky per transaction; the valids diverged.
REQ-013 timingLeakDone  output  1  one-cycle pulse; transaction finished and verdict final.
REQ-014 resultMismatch  output  1  captured results differ; valid when done is high.
REQ-015 timeout  output  1  transaction ended by TIMEOUT; valid when done is high.
REQ-016 bothValid  output  1  combinational validOne & validTwo.
REQ-017 busy  output  1  high while the FSM is in RUN.

Function
REQ-018 FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on in_fire.
- RUN -> DONE when both sides are captured, or when cyc = TIMEOUT-1.
- DONE -> IDLE after exactly one cycle.
REQ-019 On IDLE->RUN: cyc=0, both captured flags clear, timingLeak/timeout/resultMismatch clear, latencies and skew zero.
REQ-020 In RUN, cyc increments by 1 per cycle and saturates at all-ones.
REQ-021 out_ready is 1 in RUN only and 0 in IDLE and DONE.
REQ-022 A side is captured in the first RUN cycle where its valid=1 (out_ready=1): latency=cyc and result is stored. Later valids from a captured side are ignored.
REQ-023 timingLeak sets in any RUN cycle where validOne != validTwo and at least one side is not yet captured. It stays set until the next in_fire.
REQ-024 Both valids in the same cycle capture both sides; timingLeak does not set from that cycle.
REQ-025 On timeout, timeout=1 and timingLeak=1; uncaptured latencies read all-ones.
REQ-026 In DONE:
- timingLeakDone=1 for exactly one cycle.
- resultMismatch = (stored one != stored two); forced 0 if timeout.
- skew is computed from the captured latencies.
REQ-027 in_fire in RUN or DONE is ignored; flag outputs keep their DONE values until the next accepted in_fire.
REQ-028 Latency arithmetic is unsigned CNT_W; skew is the absolute difference with no wrap.

Reset
REQ-029 Reset asserted at any time, including mid-transaction, forces state=IDLE immediately.
REQ-030 While reset is asserted, all registered outputs, counters, captured results and flags are 0, and out_ready=0.
REQ-031 After reset deasserts, the block waits in IDLE for in_fire; no partial transaction resumes.

Structure
REQ-032 A shared package holds the FSM state enum and the default RESULT_W, CNT_W and TIMEOUT constants.
REQ-033 One sub-module, se_side_capture (flag, latency and result register per SE copy), is instantiated twice.
REQ-034 The block instantiates no SE copies; it connects to their output ports at the integration level.

Verification
REQ-035 Matched: in_fire, both valids at cycle 5, results equal.
-> latencyOne=latencyTwo=5, skew=0, timingLeak=0, resultMismatch=0, timingLeakDone pulse.
REQ-036 Skewed: validOne at cycle 3, validTwo at cycle 7.
-> latencyOne=3, latencyTwo=7, skew=4, timingLeak=1.
REQ-037 Mismatch: both valids at cycle 2, resultOne=0x1, resultTwo=0x2.
-> timingLeak=0, resultMismatch=1.
REQ-038 Timeout: TIMEOUT=16, only validOne at cycle 4.
-> DONE after 16 RUN cycles, timeout=1, timingLeak=1, latencyTwo=0xFFFF.
REQ-039 Reset mid-RUN: reset at cycle 3.
-> state=IDLE and outputs 0 the same cycle, no timingLeakDone pulse; a subsequent transaction measures correctly.
REQ-040 Extra in_fire during RUN at cycle 2.
-> ignored; cyc is not restarted.
